// File: rtl/time_set_stepper_pkg.sv
// Shared definitions for the time/alarm setting pushbutton front-end.
//   state_e      : FSM state encoding (3 bits, fixed values)
//   DIR_UP/DOWN  : direction encoding on dir (also used by the counters)
//   single_press : exactly one button held while setting mode is active
package time_set_stepper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HOLD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic single_press(input logic en, input logic su, input logic sd);
    return en & (su ^ sd);
  endfunction

endpackage

// File: rtl/time_set_stepper_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
//   clk : destination clock
//   rst : asynchronous, active-high reset; both flops clear to 0
//   d_i : raw asynchronous input
//   q_o : synchronized output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/time_set_stepper.sv
// Pushbutton front-end for the clock time/alarm setting path. Turns the raw
// up/down buttons into a one-cycle step pulse plus direction, with
// synchronization, debounce and hold-to-auto-repeat.
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   set_en    : setting mode active; steps only while high
//   btn_up    : raw up button, active-high
//   btn_down  : raw down button, active-high
//   step      : one-cycle pulse, drives the counter enable
//   dir       : 0 = up, 1 = down; valid whenever step = 1
//   repeating : high while auto-repeat is active
//
// state         | meaning
// --------------|-----------------------------------------------------
// ST_IDLE       | waiting for a single press
// ST_PRESS_DB   | press seen, counting stable cycles before first step
// ST_HOLD       | first step issued, waiting for auto-repeat delay
// ST_REPEAT     | auto-repeat active, step every REPEAT_CYCLES+1 cycles
// ST_RELEASE_DB | waiting for both buttons low for DB_CYCLES cycles
//
// DB_CYCLES must be at least 2: the press debounce counts the first
// accepted cycle as 1 on entry to ST_PRESS_DB.
module time_set_stepper
  import time_set_stepper_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES   = 10,
  parameter int unsigned REPEAT_CYCLES = 3,
  parameter int unsigned CW            = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic set_en,
  input  logic btn_up,
  input  logic btn_down,
  output logic step,
  output logic dir,
  output logic repeating
);

  logic su;
  logic sd;

  sync_2ff u_sync_up (
    .clk (clk),
    .rst (rst),
    .d_i (btn_up),
    .q_o (su)
  );

  sync_2ff u_sync_down (
    .clk (clk),
    .rst (rst),
    .d_i (btn_down),
    .q_o (sd)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          rep_q, rep_d;

  logic [CW-1:0] timer_inc;
  logic          press;
  logic          same_press;

  assign timer_inc  = timer_q + CW'(1);
  assign press      = single_press(set_en, su, sd);
  // pdir is sd whenever exactly one button is down
  assign same_press = press && (sd == dir_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= DIR_UP;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    rep_d   = rep_q;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          dir_d   = sd;
          timer_d = CW'(1);
          state_d = ST_PRESS_DB;
        end
      end

      ST_PRESS_DB: begin
        if (same_press) begin
          if (timer_inc == CW'(DB_CYCLES)) begin
            step_d  = 1'b1;
            timer_d = '0;
            state_d = ST_HOLD;
          end else begin
            timer_d = timer_inc;
          end
        end else begin
          timer_d = '0;
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (!same_press) begin
          rep_d   = 1'b0;
          timer_d = '0;
          state_d = ST_RELEASE_DB;
        end else if (!step_q) begin
          // the step cycle itself is not counted, giving HOLD_CYCLES+1 spacing
          if (timer_inc == CW'(HOLD_CYCLES)) begin
            step_d  = 1'b1;
            rep_d   = 1'b1;
            timer_d = '0;
            state_d = ST_REPEAT;
          end else begin
            timer_d = timer_inc;
          end
        end
      end

      ST_REPEAT: begin
        if (!same_press) begin
          rep_d   = 1'b0;
          timer_d = '0;
          state_d = ST_RELEASE_DB;
        end else if (!step_q) begin
          if (timer_inc == CW'(REPEAT_CYCLES)) begin
            step_d  = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
      end

      ST_RELEASE_DB: begin
        if (su || sd) begin
          timer_d = '0;
        end else if (timer_inc == CW'(DB_CYCLES)) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        rep_d   = 1'b0;
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign repeating = rep_q;

endmodule

// File: tb/tb_time_set_stepper.sv
// Scoreboard bench for time_set_stepper with default parameters.
// Edge numbering: a step observed at the negedge following posedge n is
// reported as consumed at edge n+1. Button changes are driven right after a
// negedge, so the following posedge is edge 0 of that press.
module tb_time_set_stepper;
  import time_set_stepper_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic set_en;
  logic btn_up;
  logic btn_down;
  logic step;
  logic dir;
  logic repeating;

  time_set_stepper dut (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .step      (step),
    .dir       (dir),
    .repeating (repeating)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int   at_edge;
    logic dir;
    logic rep;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // monitor: every step pulse is matched against the oldest expectation
  initial begin
    exp_t it;
    logic prev_step;
    prev_step = 1'b0;
    forever begin
      @(negedge clk);
      if (step) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_step: got step at edge %0d dir=%0b rep=%0b, want no step",
                   cyc + 1, dir, repeating);
        end else begin
          it = exp_q.pop_front();
          if ((cyc + 1) != it.at_edge || dir !== it.dir || repeating !== it.rep) begin
            bad = bad + 1;
            $display("FAIL step_out: got edge %0d dir=%0b rep=%0b, want edge %0d dir=%0b rep=%0b",
                     cyc + 1, dir, repeating, it.at_edge, it.dir, it.rep);
          end
        end
        total = total + 1;
        if (prev_step) begin
          bad = bad + 1;
          $display("FAIL step_back_to_back: got step high at edges %0d and %0d, want isolated pulse",
                   cyc, cyc + 1);
        end
      end
      prev_step = step;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic push_step(input int base, input int off, input logic d, input logic r);
    exp_t it;
    it.at_edge = base + off;
    it.dir     = d;
    it.rep     = r;
    exp_q.push_back(it);
  endtask

  task automatic drain(input string name);
    tick(12);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d steps missing (next at edge %0d), want 0 missing",
               name, exp_q.size(), exp_q[0].at_edge);
      exp_q.delete();
    end
  endtask

  // raise the selected buttons for len cycles (edges 0..len-1), then drop them
  task automatic press(input logic up, input logic down, input int len);
    btn_up   = up;
    btn_down = down;
    tick(len);
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  int base;
  int rep_steps[8] = '{6, 17, 21, 25, 29, 33, 37, 41};

  initial begin
    rst      = 1'b1;
    set_en   = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(3);
    check("rst_step", 32'(step), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_repeating", 32'(repeating), 0);
    rst = 1'b0;
    tick(3);
    check("idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("idle_step", 32'(step), 0);

    // up pulse of 3 cycles is one short of the debounce: no step
    press(1'b1, 1'b0, 3);
    tick(8);
    check("short_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("short_dir", 32'(dir), 32'(DIR_UP));
    drain("short_press");

    // up pulse of exactly 4 cycles: one step at edge 6
    base = cyc + 1;
    push_step(base, 6, DIR_UP, 1'b0);
    press(1'b1, 1'b0, 4);
    drain("exact_db_press");

    // down held 8 cycles: one step, dir down, no repeat
    base = cyc + 1;
    push_step(base, 6, DIR_DOWN, 1'b0);
    press(1'b0, 1'b1, 8);
    tick(3);
    check("down8_repeating", 32'(repeating), 0);
    drain("down8");

    // up held 40 cycles: first step, hold delay, then repeats every 4
    base = cyc + 1;
    foreach (rep_steps[i]) push_step(base, rep_steps[i], DIR_UP, (i == 0) ? 1'b0 : 1'b1);
    btn_up = 1'b1;
    tick(16);
    check("hold_repeating_before", 32'(repeating), 0);
    tick(4);
    check("hold_repeating_active", 32'(repeating), 1);
    tick(20);
    btn_up = 1'b0;
    tick(2);
    check("hold_repeating_last", 32'(repeating), 1);
    tick(1);
    check("hold_repeating_released", 32'(repeating), 0);
    drain("hold40");

    // both buttons together for 30 cycles: nothing
    press(1'b1, 1'b1, 30);
    tick(6);
    check("both_state", 32'(dut.state_q), 32'(ST_IDLE));
    drain("both_pressed");
    base = cyc + 1;
    push_step(base, 6, DIR_UP, 1'b0);
    press(1'b1, 1'b0, 8);
    drain("after_both");

    // reset while holding up: outputs clear at once, latency restarts
    base = cyc + 1;
    push_step(base, 6, DIR_UP, 1'b0);
    push_step(base, 17, DIR_UP, 1'b1);
    btn_up = 1'b1;
    tick(20);
    #2 rst = 1'b1;
    #1;
    check("midrst_step", 32'(step), 0);
    check("midrst_repeating", 32'(repeating), 0);
    check("midrst_dir", 32'(dir), 0);
    tick(2);
    rst = 1'b0;
    base = cyc + 1;
    push_step(base, 6, DIR_UP, 1'b0);
    push_step(base, 17, DIR_UP, 1'b1);
    push_step(base, 21, DIR_UP, 1'b1);
    push_step(base, 25, DIR_UP, 1'b1);
    tick(24);
    btn_up = 1'b0;
    drain("reset_restart");

    // set_en dropped while holding down, then raised again while held
    base = cyc + 1;
    push_step(base, 6, DIR_DOWN, 1'b0);
    btn_down = 1'b1;
    tick(15);
    set_en = 1'b0;
    tick(10);
    check("seten_repeating", 32'(repeating), 0);
    check("seten_state", 32'(dut.state_q), 32'(ST_RELEASE_DB));
    set_en = 1'b1;
    tick(20);
    check("seten_reraised_state", 32'(dut.state_q), 32'(ST_RELEASE_DB));
    btn_down = 1'b0;
    tick(10);
    check("seten_release_state", 32'(dut.state_q), 32'(ST_IDLE));
    drain("seten_drop");
    base = cyc + 1;
    push_step(base, 6, DIR_DOWN, 1'b0);
    press(1'b0, 1'b1, 8);
    drain("seten_new_press");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_stepper.md
Name: time_set_stepper

Overview:
- Pushbutton front-end for the alarm-clock time/alarm setting path.
- Conditions two raw buttons (up, down) into the step interface of the up/down modulo counters: a single-cycle enable pulse plus a direction bit.
- Applies synchronization, debounce, and hold-to-auto-repeat.
- Sits between the board button pins and the en/upDown inputs of the hour/minute counters.

Parameters:
- DB_CYCLES, default 4, number of consecutive stable synchronized cycles required to accept a press or release.
- HOLD_CYCLES, default 10, cycles from the first step until the first auto-repeat step.
- REPEAT_CYCLES, default 3, cycles between successive auto-repeat steps.
- CW, default 24, timer width; must hold max(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- set_en  in  1  setting mode active; steps are only generated while high.
- btn_up  in  1  raw, asynchronous up button, active-high.
- btn_down  in  1  raw, asynchronous down button, active-high.
- step  out  1  one-cycle pulse; drives the counter's en.
- dir  out  1  0 = count up, 1 = count down; drives the counter's upDown; valid whenever step=1.
- repeating  out  1  high while auto-repeat is active.

Behaviour:
- Reset:
  - All outputs are 0.
  - Both 2-FF synchronizers clear to 0.
  - Timer is 0.
  - FSM is in IDLE.
  - Reset mid-operation aborts immediately; no step is emitted after reset deassertion unless a fresh press is accepted.
- Inputs and registers:
  - Inputs pass through 2-FF synchronizers to give su and sd.
  - All FSM logic uses su/sd only.
  - step, dir and repeating are registered outputs.
- Definitions:
  - "single press" = set_en & (su ^ sd).
  - pdir = sd, sampled only when single press holds.
- FSM states: IDLE, PRESS_DB, HOLD, REPEAT, RELEASE_DB.
- IDLE:
  - If single press: latch dir<=pdir, set timer=1, go to PRESS_DB.
  - Otherwise stay.
- PRESS_DB:
  - If single press with the same pdir: timer++.
  - When timer reaches DB_CYCLES: pulse step=1 for the next cycle, clear timer, go to HOLD.
  - Any deviation (release, other button, both pressed, set_en low): go to IDLE, no step.
- HOLD:
  - While single press with the same dir: timer++.
  - When timer reaches HOLD_CYCLES: pulse step, set repeating=1, clear timer, go to REPEAT.
- REPEAT:
  - While single press with the same dir: timer++.
  - When timer reaches REPEAT_CYCLES: pulse step, clear timer.
  - repeating stays 1.
- Leaving HOLD/REPEAT:
  - If the held button goes low, the other button is added, or set_en drops: clear repeating, clear timer, go to RELEASE_DB.
  - No step is emitted on that cycle.
- RELEASE_DB:
  - Requires su=0 and sd=0 for DB_CYCLES consecutive cycles, then go to IDLE.
  - Any high resets the timer.
- Direction and step rules:
  - dir changes only on the IDLE to PRESS_DB transition; it is constant during a press sequence.
  - step is never high on two consecutive cycles.
- Both buttons pressed:
  - No step is ever generated.
  - From IDLE, stay in IDLE.
  - In HOLD/REPEAT, go to RELEASE_DB.
- set_en low:
  - Suppresses all steps.
  - If already pressed, the FSM must pass through RELEASE_DB before a new press is accepted.
- Latency: btn_up rising before clk edge 0, held steady → first step high in the cycle after edge 2+DB_CYCLES−1 (edge 5 for defaults), i.e. step observed at edge 6.
- Repeat timing:
  - Second step follows the first by HOLD_CYCLES+1 cycles.
  - Subsequent steps are spaced REPEAT_CYCLES+1 cycles apart.
  - The timer counts from 0 after the step cycle.
- Timer is CW bits and never wraps; comparisons use equality.

Decomposition:
- Shared package/header:
  - FSM state encoding constants (3-bit: IDLE=0, PRESS_DB=1, HOLD=2, REPEAT=3, RELEASE_DB=4).
  - The DIR_UP=0/DIR_DOWN=1 constants, also used by the counter instantiation.
- One sub-module: sync_2ff (1-bit, async reset to 0), instantiated twice.
- FSM and timer stay in time_set_stepper.

Test Plan:
- Defaults, set_en=1, btn_up pulsed high for 3 cycles then low → zero steps; FSM returns to IDLE; dir unchanged.
- btn_down held 8 cycles then released → exactly one step with dir=1, first observed at edge 6; repeating stays 0.
- btn_up held 40 cycles → steps at edges 6, 17, 21, 25, 29, 33, 37, 41 (0 < steps ≤ 3 cycles after release); repeating=1 from edge 17 until release; dir=0 throughout.
- Both buttons raised together and held 30 cycles → no step; then both released and btn_up pressed → one step after debounce.
- btn_up held, rst asserted at edge 20 for 2 cycles while still held → all outputs 0 immediately; first post-reset step only after full sync+debounce latency; repeat timing restarts.
- btn_down held, set_en dropped at edge 15 → no further steps; repeating=0; set_en re-raised while held → no step until release (DB_CYCLES low) and a new press.
